// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops one FIFO word per frame and serialises start/data/parity/stop.
// Start bit begins 3 cycles after a non-empty FIFO is seen; the FIFO is only read in FETCH.
module uart_tx_ctrl #(
  parameter int DataWidth  = 8,
  parameter int ClksPerBit = 868,
  parameter int ParityMode = 0,
  parameter int StopBits   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 fifo_empty_i,
  input  logic [DataWidth-1:0] fifo_rdata_i,
  output logic                 fifo_rd_en_o,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 frame_done_o
);

  localparam int BaudW = $clog2(ClksPerBit);
  localparam int BitW  = $clog2(DataWidth);

  if (ClksPerBit < 2) begin : g_chk_clks
    $error("uart_tx_ctrl: ClksPerBit must be >= 2");
  end
  if (ParityMode < 0 || ParityMode > 2) begin : g_chk_parity
    $error("uart_tx_ctrl: ParityMode must be 0, 1 or 2");
  end
  if (StopBits < 1 || StopBits > 2) begin : g_chk_stop
    $error("uart_tx_ctrl: StopBits must be 1 or 2");
  end
  if (DataWidth < 5 || DataWidth > 9) begin : g_chk_width
    $error("uart_tx_ctrl: DataWidth must be 5..9");
  end

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
  } state_e;

  state_e               state_q, state_d;
  logic [BaudW-1:0]     baud_q, baud_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DataWidth-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;

  logic baud_end;
  logic data_last;
  logic stop_last;
  logic start_ok;

  assign baud_end  = (baud_q == BaudW'(ClksPerBit - 1));
  assign data_last = (bit_q == BitW'(DataWidth - 1));
  assign stop_last = (bit_q == BitW'(StopBits - 1));
  assign start_ok  = enable_i && !fifo_empty_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
    end
  end

  // Baud counter restarts on every bit boundary; the bit counter also indexes stop bits.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) state_d = FETCH;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        shift_d  = fifo_rdata_i;
        parity_d = (^fifo_rdata_i) ^ (ParityMode == 2);
        baud_d   = '0;
        bit_d    = '0;
        state_d  = START;
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (data_last) begin
            bit_d   = '0;
            state_d = (ParityMode != 0) ? PARITY : STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (stop_last) begin
            bit_d   = '0;
            state_d = start_ok ? FETCH : IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is chosen from the state being entered so tx_o stays a plain flop.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_q;
      default: tx_d = 1'b1;
    endcase
    fifo_rd_en_o = (state_q == FETCH);
    busy_o       = (state_q != IDLE);
    frame_done_o = (state_q == STOP) && baud_end && stop_last;
    tx_o         = tx_q;
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench: three transmitters (no/even/odd parity, 4 clocks per bit) each fed by a small FIFO model.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [2:0] empty_w;
  logic [2:0] rd_en_w;
  logic [2:0] tx_w;
  logic [2:0] busy_w;
  logic [2:0] done_w;
  logic [7:0] rdata_w [3];

  logic [7:0] mem [3][16];
  int wp [3];
  int rp [3];
  int rd_cnt [3];
  int rd_bad [3];
  int done_cnt [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DataWidth(8), .ClksPerBit(4), .ParityMode(0), .StopBits(1)) u_p0 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .fifo_empty_i(empty_w[0]),
    .fifo_rdata_i(rdata_w[0]), .fifo_rd_en_o(rd_en_w[0]), .tx_o(tx_w[0]),
    .busy_o(busy_w[0]), .frame_done_o(done_w[0]));

  uart_tx_ctrl #(.DataWidth(8), .ClksPerBit(4), .ParityMode(1), .StopBits(1)) u_p1 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .fifo_empty_i(empty_w[1]),
    .fifo_rdata_i(rdata_w[1]), .fifo_rd_en_o(rd_en_w[1]), .tx_o(tx_w[1]),
    .busy_o(busy_w[1]), .frame_done_o(done_w[1]));

  uart_tx_ctrl #(.DataWidth(8), .ClksPerBit(4), .ParityMode(2), .StopBits(1)) u_p2 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .fifo_empty_i(empty_w[2]),
    .fifo_rdata_i(rdata_w[2]), .fifo_rd_en_o(rd_en_w[2]), .tx_o(tx_w[2]),
    .busy_o(busy_w[2]), .frame_done_o(done_w[2]));

  always_comb begin
    for (int i = 0; i < 3; i++) empty_w[i] = (wp[i] == rp[i]);
  end

  // FIFO model with registered read data, one-cycle latency.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd_en_w[i] === 1'b1) begin
        rd_cnt[i] <= rd_cnt[i] + 1;
        if (wp[i] != rp[i]) begin
          rdata_w[i] <= mem[i][rp[i] % 16];
          rp[i]      <= rp[i] + 1;
        end else begin
          rd_bad[i] <= rd_bad[i] + 1;
        end
      end
      if (done_w[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
    end
  end

  task automatic push(input int idx, input logic [7:0] d);
    mem[idx][wp[idx] % 16] = d;
    wp[idx] = wp[idx] + 1;
  endtask

  // Call on a negedge where the DUT will enter FETCH at the next posedge.
  // pat holds the line levels in transmit order (bit 0 = start bit).
  task automatic check_frame(input int idx, input int nbits, input logic [10:0] pat,
                             input string name, input int drop_at);
    logic [43:0] tx_obs, tx_exp, fd_obs, fd_exp, bz_obs, bz_exp;
    int nc;
    nc = nbits * 4;
    tx_obs = '0; tx_exp = '0; fd_obs = '0; fd_exp = '0; bz_obs = '0; bz_exp = '0;
    for (int k = 0; k < nc; k++) begin
      tx_exp[k] = pat[k / 4];
      fd_exp[k] = (k == nc - 1);
      bz_exp[k] = 1'b1;
    end
    @(negedge clk);
    n_cmp++;
    if (rd_en_w[idx] !== 1'b1) begin
      n_err++;
      $display("FAIL %s fetch_rd_en: got %b want 1", name, rd_en_w[idx]);
    end
    @(negedge clk);
    n_cmp++;
    if ({rd_en_w[idx], tx_w[idx]} !== 2'b01) begin
      n_err++;
      $display("FAIL %s load_cycle rd_en,tx: got %b want 01", name, {rd_en_w[idx], tx_w[idx]});
    end
    for (int k = 0; k < nc; k++) begin
      @(negedge clk);
      if (k == drop_at) enable = 1'b0;
      tx_obs[k] = tx_w[idx];
      fd_obs[k] = done_w[idx];
      bz_obs[k] = busy_w[idx];
    end
    n_cmp++;
    if (tx_obs !== tx_exp) begin
      n_err++;
      $display("FAIL %s line: got %h want %h", name, tx_obs, tx_exp);
    end
    n_cmp++;
    if (fd_obs !== fd_exp) begin
      n_err++;
      $display("FAIL %s frame_done: got %h want %h", name, fd_obs, fd_exp);
    end
    n_cmp++;
    if (bz_obs !== bz_exp) begin
      n_err++;
      $display("FAIL %s busy: got %h want %h", name, bz_obs, bz_exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (tx_w !== 3'b111) begin n_err++; $display("FAIL reset_tx: got %b want 111", tx_w); end
    n_cmp++;
    if (busy_w !== 3'b000) begin n_err++; $display("FAIL reset_busy: got %b want 000", busy_w); end
    n_cmp++;
    if (rd_en_w !== 3'b000) begin n_err++; $display("FAIL reset_rd_en: got %b want 000", rd_en_w); end
    n_cmp++;
    if (done_w !== 3'b000) begin n_err++; $display("FAIL reset_done: got %b want 000", done_w); end
    rst = 1'b0;
  endtask

  task automatic test_idle_empty();
    int bad_tx, bad_busy, bad_rd;
    bad_tx = 0; bad_busy = 0; bad_rd = 0;
    enable = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (tx_w !== 3'b111) bad_tx++;
      if (busy_w !== 3'b000) bad_busy++;
      if (rd_en_w !== 3'b000) bad_rd++;
    end
    n_cmp++;
    if (bad_tx != 0) begin n_err++; $display("FAIL idle_tx: %0d bad cycles, want 0", bad_tx); end
    n_cmp++;
    if (bad_busy != 0) begin n_err++; $display("FAIL idle_busy: %0d bad cycles, want 0", bad_busy); end
    n_cmp++;
    if (bad_rd != 0) begin n_err++; $display("FAIL idle_rd_en: %0d bad cycles, want 0", bad_rd); end
  endtask

  task automatic test_frame_a5();
    int rd0, fd0;
    rd0 = rd_cnt[0]; fd0 = done_cnt[0];
    push(0, 8'hA5);
    check_frame(0, 10, {1'b0, 1'b1, 8'hA5, 1'b0}, "a5", -1);
    @(negedge clk);
    n_cmp++;
    if ({busy_w[0], tx_w[0]} !== 2'b01) begin
      n_err++; $display("FAIL a5_after busy,tx: got %b want 01", {busy_w[0], tx_w[0]});
    end
    n_cmp++;
    if (rd_cnt[0] - rd0 != 1) begin n_err++; $display("FAIL a5_rd_pulses: got %0d want 1", rd_cnt[0] - rd0); end
    n_cmp++;
    if (done_cnt[0] - fd0 != 1) begin n_err++; $display("FAIL a5_done_pulses: got %0d want 1", done_cnt[0] - fd0); end
  endtask

  task automatic test_parity();
    push(1, 8'h07);
    check_frame(1, 11, {1'b1, 1'b1, 8'h07, 1'b0}, "even_07", -1);
    @(negedge clk);
    n_cmp++;
    if (busy_w[1] !== 1'b0) begin n_err++; $display("FAIL even_after busy: got %b want 0", busy_w[1]); end
    push(2, 8'h07);
    check_frame(2, 11, {1'b1, 1'b0, 8'h07, 1'b0}, "odd_07", -1);
    @(negedge clk);
    n_cmp++;
    if (busy_w[2] !== 1'b0) begin n_err++; $display("FAIL odd_after busy: got %b want 0", busy_w[2]); end
  endtask

  task automatic test_back_to_back();
    int rd0;
    rd0 = rd_cnt[0];
    push(0, 8'h55);
    push(0, 8'hAA);
    push(0, 8'h0F);
    check_frame(0, 10, {1'b0, 1'b1, 8'h55, 1'b0}, "b2b_55", -1);
    check_frame(0, 10, {1'b0, 1'b1, 8'hAA, 1'b0}, "b2b_aa", -1);
    check_frame(0, 10, {1'b0, 1'b1, 8'h0F, 1'b0}, "b2b_0f", -1);
    @(negedge clk);
    n_cmp++;
    if ({busy_w[0], rd_en_w[0], tx_w[0]} !== 3'b001) begin
      n_err++; $display("FAIL b2b_after busy,rd_en,tx: got %b want 001", {busy_w[0], rd_en_w[0], tx_w[0]});
    end
    n_cmp++;
    if (rd_cnt[0] - rd0 != 3) begin n_err++; $display("FAIL b2b_rd_pulses: got %0d want 3", rd_cnt[0] - rd0); end
    n_cmp++;
    if (empty_w[0] !== 1'b1) begin n_err++; $display("FAIL b2b_fifo_empty: got %b want 1", empty_w[0]); end
  endtask

  task automatic test_enable_drop();
    int rd0, bad;
    rd0 = rd_cnt[0]; bad = 0;
    push(0, 8'h55);
    push(0, 8'hAA);
    check_frame(0, 10, {1'b0, 1'b1, 8'h55, 1'b0}, "drop_55", 18);
    repeat (20) begin
      @(negedge clk);
      if ({busy_w[0], rd_en_w[0], tx_w[0]} !== 3'b001) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL drop_idle: %0d bad cycles, want 0", bad); end
    n_cmp++;
    if (rd_cnt[0] - rd0 != 1) begin n_err++; $display("FAIL drop_rd_pulses: got %0d want 1", rd_cnt[0] - rd0); end
    n_cmp++;
    if (empty_w[0] !== 1'b0) begin n_err++; $display("FAIL drop_aa_kept empty: got %b want 0", empty_w[0]); end
    enable = 1'b1;
    check_frame(0, 10, {1'b0, 1'b1, 8'hAA, 1'b0}, "drop_aa", -1);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int fd0;
    push(0, 8'h3C);
    push(0, 8'h81);
    fd0 = done_cnt[0];
    @(negedge clk);
    n_cmp++;
    if (rd_en_w[0] !== 1'b1) begin n_err++; $display("FAIL rstmid_fetch rd_en: got %b want 1", rd_en_w[0]); end
    // LOAD, then start bit (4) + data bits 0..2 (12) + 2 cycles into data bit 3
    repeat (19) @(negedge clk);
    n_cmp++;
    if (tx_w[0] !== 1'b1) begin n_err++; $display("FAIL rstmid_bit3 tx: got %b want 1", tx_w[0]); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy_w[0], tx_w[0], done_w[0]} !== 3'b010) begin
      n_err++; $display("FAIL rstmid_after busy,tx,done: got %b want 010", {busy_w[0], tx_w[0], done_w[0]});
    end
    rst = 1'b0;
    n_cmp++;
    if (done_cnt[0] != fd0) begin n_err++; $display("FAIL rstmid_done_pulses: got %0d want 0", done_cnt[0] - fd0); end
    check_frame(0, 10, {1'b0, 1'b1, 8'h81, 1'b0}, "rstmid_81", -1);
    @(negedge clk);
    n_cmp++;
    if (busy_w[0] !== 1'b0) begin n_err++; $display("FAIL rstmid_end busy: got %b want 0", busy_w[0]); end
  endtask

  task automatic test_no_empty_reads();
    n_cmp++;
    if (rd_bad[0] + rd_bad[1] + rd_bad[2] != 0) begin
      n_err++; $display("FAIL rd_while_empty: got %0d want 0", rd_bad[0] + rd_bad[1] + rd_bad[2]);
    end
  endtask

  initial begin
    test_reset();
    test_idle_empty();
    test_frame_a5();
    test_parity();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    test_no_empty_reads();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
